// File: rtl/ram_1r1w_arbiter.sv
// Shares one ram_1r1w between N_RD read and N_WR write requesters over valid/ready handshakes.
// Define RAM_ARB_WR_PRIO_EN to give writes strict priority over reads; otherwise the classes alternate.
module ram_1r1w_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int SIZE           = 256,
  parameter int NUM_PARTITIONS = 4,
  parameter int ADDR_WIDTH     = 8,
  parameter int N_RD           = 2,
  parameter int N_WR           = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_RD-1:0]                rd_req_valid,
  output logic [N_RD-1:0]                rd_req_ready,
  input  logic [N_RD*ADDR_WIDTH-1:0]     rd_req_addr,
  input  logic [N_RD*NUM_PARTITIONS-1:0] rd_req_mask,
  output logic [N_RD-1:0]                rd_resp_valid,
  input  logic [N_RD-1:0]                rd_resp_ready,
  output logic [N_RD*DATA_WIDTH-1:0]     rd_resp_data,
  input  logic [N_WR-1:0]                wr_req_valid,
  output logic [N_WR-1:0]                wr_req_ready,
  input  logic [N_WR*ADDR_WIDTH-1:0]     wr_req_addr,
  input  logic [N_WR*DATA_WIDTH-1:0]     wr_req_data,
  input  logic [N_WR*NUM_PARTITIONS-1:0] wr_req_mask,
  output logic [N_WR-1:0]                wr_resp_valid,
  input  logic [N_WR-1:0]                wr_resp_ready,
  output logic                           ram_rd_en,
  output logic [ADDR_WIDTH-1:0]          ram_rd_addr,
  output logic [NUM_PARTITIONS-1:0]      ram_rd_mask,
  input  logic [DATA_WIDTH-1:0]          ram_rd_data,
  output logic                           ram_wr_en,
  output logic [ADDR_WIDTH-1:0]          ram_wr_addr,
  output logic [DATA_WIDTH-1:0]          ram_wr_data,
  output logic [NUM_PARTITIONS-1:0]      ram_wr_mask
);

  localparam int RD_W   = (N_RD > 1) ? $clog2(N_RD) : 1;
  localparam int WR_W   = (N_WR > 1) ? $clog2(N_WR) : 1;
  localparam int LANE_W = DATA_WIDTH / NUM_PARTITIONS;

  if ((DATA_WIDTH % NUM_PARTITIONS) != 0 || SIZE > (1 << ADDR_WIDTH)) begin : g_param_check
    $error("ram_1r1w_arbiter: inconsistent DATA_WIDTH/NUM_PARTITIONS or SIZE/ADDR_WIDTH");
  end

  logic [N_RD-1:0]           rd_slot_valid, rd_elig;
  logic [DATA_WIDTH-1:0]     rd_slot_data [N_RD];
  logic [N_WR-1:0]           wr_slot_valid, wr_elig;
  logic [RD_W-1:0]           rd_ptr, rd_pick, rd_pend_id;
  logic [WR_W-1:0]           wr_ptr, wr_pick;
  logic                      rd_found, wr_found, grant_rd, grant_wr;
  logic                      rd_pend_valid;
  logic [NUM_PARTITIONS-1:0] rd_pend_mask;
  logic [DATA_WIDTH-1:0]     rd_lane_mask;

  // A reader with a read in flight is busy even though its slot is not yet filled.
  always_comb begin
    for (int i = 0; i < N_RD; i++)
      rd_elig[i] = rd_req_valid[i] & ~rd_slot_valid[i] & ~(rd_pend_valid && rd_pend_id == RD_W'(i));
  end

  assign wr_elig = wr_req_valid & ~wr_slot_valid;

  always_comb begin
    rd_found = 1'b0;
    rd_pick  = '0;
    for (int k = 0; k < N_RD; k++)
      for (int j = 0; j < N_RD; j++)
        if (!rd_found && rd_elig[j] && j == (int'(rd_ptr) + 1 + k) % N_RD) begin
          rd_found = 1'b1;
          rd_pick  = RD_W'(j);
        end
  end

  always_comb begin
    wr_found = 1'b0;
    wr_pick  = '0;
    for (int k = 0; k < N_WR; k++)
      for (int j = 0; j < N_WR; j++)
        if (!wr_found && wr_elig[j] && j == (int'(wr_ptr) + 1 + k) % N_WR) begin
          wr_found = 1'b1;
          wr_pick  = WR_W'(j);
        end
  end

`ifdef RAM_ARB_WR_PRIO_EN
  assign grant_wr = rst & wr_found;
  assign grant_rd = rst & rd_found & ~wr_found;
`else
  logic read_first;

  assign grant_rd = rst & rd_found & (~wr_found | read_first);
  assign grant_wr = rst & wr_found & ~(rd_found & read_first);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      read_first <= 1'b1;
    else if (rd_found && wr_found)
      read_first <= ~read_first;
  end
`endif

  always_comb begin
    rd_req_ready = '0;
    wr_req_ready = '0;
    ram_rd_en    = 1'b0;
    ram_rd_addr  = '0;
    ram_rd_mask  = '0;
    ram_wr_en    = 1'b0;
    ram_wr_addr  = '0;
    ram_wr_data  = '0;
    ram_wr_mask  = '0;
    if (grant_rd) begin
      rd_req_ready[rd_pick] = 1'b1;
      ram_rd_en   = 1'b1;
      ram_rd_addr = rd_req_addr[rd_pick*ADDR_WIDTH +: ADDR_WIDTH];
      ram_rd_mask = rd_req_mask[rd_pick*NUM_PARTITIONS +: NUM_PARTITIONS];
    end
    if (grant_wr) begin
      wr_req_ready[wr_pick] = 1'b1;
      ram_wr_en   = 1'b1;
      ram_wr_addr = wr_req_addr[wr_pick*ADDR_WIDTH +: ADDR_WIDTH];
      ram_wr_data = wr_req_data[wr_pick*DATA_WIDTH +: DATA_WIDTH];
      ram_wr_mask = wr_req_mask[wr_pick*NUM_PARTITIONS +: NUM_PARTITIONS];
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PARTITIONS; p++)
      rd_lane_mask[p*LANE_W +: LANE_W] = {LANE_W{rd_pend_mask[p]}};
  end

  // The read id and mask ride one cycle behind the grant to meet the RAM's registered data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      rd_pend_valid <= 1'b0;
      rd_pend_id    <= '0;
      rd_pend_mask  <= '0;
      rd_slot_valid <= '0;
      wr_slot_valid <= '0;
      for (int i = 0; i < N_RD; i++)
        rd_slot_data[i] <= '0;
    end else begin
      rd_pend_valid <= grant_rd;
      if (grant_rd) begin
        rd_ptr       <= rd_pick;
        rd_pend_id   <= rd_pick;
        rd_pend_mask <= ram_rd_mask;
      end
      if (grant_wr)
        wr_ptr <= wr_pick;
      for (int i = 0; i < N_RD; i++)
        if (rd_slot_valid[i] && rd_resp_ready[i])
          rd_slot_valid[i] <= 1'b0;
      if (rd_pend_valid) begin
        rd_slot_valid[rd_pend_id] <= 1'b1;
        rd_slot_data[rd_pend_id]  <= ram_rd_data & rd_lane_mask;
      end
      for (int i = 0; i < N_WR; i++)
        if (wr_slot_valid[i] && wr_resp_ready[i])
          wr_slot_valid[i] <= 1'b0;
      if (grant_wr)
        wr_slot_valid[wr_pick] <= 1'b1;
    end
  end

  assign rd_resp_valid = rd_slot_valid;
  assign wr_resp_valid = wr_slot_valid;

  always_comb begin
    for (int i = 0; i < N_RD; i++)
      rd_resp_data[i*DATA_WIDTH +: DATA_WIDTH] = rd_slot_data[i];
  end

endmodule
